// File: rtl/pipe_ctrl.sv
// Y86-64 PIPE pipeline control: hazard stall/bubble generation, run-state FSM
// gating the pipeline, and saturating performance counters.
module pipe_ctrl #(
  parameter int         CNT_W = 32,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_bubble,
  output logic             set_cc,
  output logic [1:0]       run_state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'b001;
  localparam logic [2:0] S_HLT = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t r_state, w_next_state;

  logic [CNT_W-1:0] r_cycle_cnt, r_retire_cnt, r_bubble_cnt;

  logic w_lu, w_rt, w_mp, w_xm, w_xw;
  logic w_retire;

  assign w_lu = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign w_mp = (E_icode == I_JXX) && !e_cnd;
  assign w_xm = (m_stat != S_AOK);
  assign w_xw = (W_stat != S_AOK);

  assign w_retire = (W_stat == S_AOK) && (W_icode != I_NOP);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    F_stall      = 1'b0;
    D_stall      = 1'b0;
    W_stall      = 1'b0;
    D_bubble     = 1'b0;
    E_bubble     = 1'b0;
    M_bubble     = 1'b0;
    W_bubble     = 1'b0;
    set_cc       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Flush: hold fetch, fill every downstream register with nops.
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_bubble = 1'b1;
        if (start) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        F_stall  = w_lu | w_rt;
        D_stall  = w_lu;
        D_bubble = w_mp | (!w_lu & w_rt);
        E_bubble = w_mp | w_lu;
        M_bubble = w_xm | w_xw;
        W_stall  = w_xw;
        set_cc   = (E_icode == I_OPQ) & !w_xm & !w_xw;
        if (W_stat == S_HLT)  w_next_state = ST_HALTED;
        else if (w_xw)        w_next_state = ST_FAULT;
      end
      default: begin
        // HALTED / FAULT freeze; only rst leaves these states.
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
    endcase
  end

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_bubble_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN) begin
        if (r_cycle_cnt != CNT_MAX) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
        if (w_retire && (r_retire_cnt != CNT_MAX))
          r_retire_cnt <= r_retire_cnt + CNT_ONE;
        if ((D_bubble || E_bubble) && (r_bubble_cnt != CNT_MAX))
          r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end
    end
  end

  assign run_state  = r_state;
  assign cycle_cnt  = r_cycle_cnt;
  assign retire_cnt = r_retire_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven RUN-state hazard vectors plus
// directed sequences for reset, start, halt/fault freeze and counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic       e_cnd;
  logic [2:0] m_stat, W_stat;

  logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, W_bubble, set_cc;
  logic [1:0]  run_state;
  logic [31:0] cycle_cnt, retire_cnt, bubble_cnt;

  logic        F_stall4, D_stall4, W_stall4, D_bubble4, E_bubble4, M_bubble4, W_bubble4, set_cc4;
  logic [1:0]  run_state4;
  logic [3:0]  cycle_cnt4, retire_cnt4, bubble_cnt4;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
    .set_cc(set_cc), .run_state(run_state),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall4), .D_stall(D_stall4), .W_stall(W_stall4),
    .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_bubble(W_bubble4),
    .set_cc(set_cc4), .run_state(run_state4),
    .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4), .bubble_cnt(bubble_cnt4)
  );

  // Control bundle order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc}
  logic [7:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, set_cc};

  localparam logic [7:0] CTL_IDLE   = 8'b1011_1010;
  localparam logic [7:0] CTL_FREEZE = 8'b1101_1100;

  typedef struct {
    logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic [2:0] m_stat;
    logic [3:0] w_icode;
    logic [7:0] ctl;
  } vec_t;

  vec_t vecs[13];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_cyc, exp_ret, exp_bub, held_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] di, sa, sb, ei, ed, input logic ec,
                              input logic [3:0] mi, input logic [2:0] ms,
                              input logic [3:0] wi, input logic [7:0] c);
    vec_t v;
    v.d_icode = di; v.srca = sa; v.srcb = sb; v.e_icode = ei; v.e_dstm = ed;
    v.e_cnd = ec; v.m_icode = mi; v.m_stat = ms; v.w_icode = wi; v.ctl = c;
    return v;
  endfunction

  task automatic drive_nops();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 1'b0;
    M_icode = 4'h1; m_stat = 3'b001; W_icode = 4'h1; W_stat = 3'b001;
  endtask

  initial begin
    //             D    srcA srcB E    dstM cnd M    mstat   W    expected ctl
    vecs[0]  = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b0000_0000);
    vecs[1]  = mk(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 0, 4'h1, 3'b001, 4'h1, 8'b1101_0000);
    vecs[2]  = mk(4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b0000_0000);
    vecs[3]  = mk(4'h1, 4'hF, 4'h2, 4'hB, 4'h2, 0, 4'h1, 3'b001, 4'h1, 8'b1101_0000);
    vecs[4]  = mk(4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b1010_0000);
    vecs[5]  = mk(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 0, 4'h1, 3'b001, 4'h1, 8'b1101_0000);
    vecs[6]  = mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b0011_0000);
    vecs[7]  = mk(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1, 4'h1, 3'b001, 4'h1, 8'b0000_0000);
    vecs[8]  = mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b0000_0001);
    vecs[9]  = mk(4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 0, 4'h1, 3'b100, 4'h1, 8'b0000_1000);
    vecs[10] = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h9, 3'b001, 4'h1, 8'b1010_0000);
    vecs[11] = mk(4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 0, 4'h1, 3'b001, 4'h1, 8'b1010_0000);
    vecs[12] = mk(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 0, 4'h1, 3'b001, 4'h6, 8'b0000_0000);

    rst = 1'b1; start = 1'b0; drive_nops();
    exp_cyc = 0; exp_ret = 0; exp_bub = 0;

    // Reset for two cycles, then IDLE flush pattern even with OPQ in E.
    repeat (2) @(negedge clk);
    rst = 1'b0; E_icode = 4'h6;
    #2;
    check("reset_state", 32'(run_state), 32'd0);
    check("reset_ctl", 32'(ctl), 32'(CTL_IDLE));
    check("reset_cycle_cnt", cycle_cnt, 32'd0);
    check("reset_retire_cnt", retire_cnt, 32'd0);
    check("reset_bubble_cnt", bubble_cnt, 32'd0);

    // Idle cycles do not count; start leaves IDLE at the next edge.
    @(negedge clk); drive_nops(); start = 1'b1;
    #2 check("idle_still_idle", 32'(run_state), 32'd0);
    @(negedge clk); start = 1'b0;
    #2;
    check("start_state", 32'(run_state), 32'd1);
    check("run_nop_ctl", 32'(ctl), 32'd0);
    check("run_first_cycle_cnt", cycle_cnt, 32'd0);
    exp_cyc++;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
      E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_cnd = vecs[i].e_cnd;
      M_icode = vecs[i].m_icode; m_stat = vecs[i].m_stat;
      W_icode = vecs[i].w_icode; W_stat = 3'b001;
      #2;
      check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      exp_cyc++;
      if (vecs[i].ctl[5] || vecs[i].ctl[4]) exp_bub++;
      if (vecs[i].w_icode != 4'h1) exp_ret++;
    end

    // Ret held in D for three cycles: fetch stalls and D bubbles every cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_nops(); D_icode = 4'h9;
      #2 check($sformatf("ret_hold%0d_ctl", i), 32'(ctl), 32'b1010_0000);
      exp_cyc++; exp_bub++;
    end

    @(negedge clk); drive_nops();
    #2;
    check("run_cycle_cnt", cycle_cnt, exp_cyc);
    check("run_bubble_cnt", bubble_cnt, exp_bub);
    check("run_retire_cnt", retire_cnt, exp_ret);
    exp_cyc++;

    // Halt seen in W: that cycle still uses RUN outputs, then freeze.
    @(negedge clk); W_stat = 3'b100; E_icode = 4'h6;
    #2;
    check("halt_cycle_state", 32'(run_state), 32'd1);
    check("halt_cycle_ctl", 32'(ctl), 32'b0000_1100);
    exp_cyc++;
    @(negedge clk); drive_nops();
    #2;
    check("halted_state", 32'(run_state), 32'd2);
    check("halted_ctl", 32'(ctl), 32'(CTL_FREEZE));
    check("halted_cycle_cnt", cycle_cnt, exp_cyc);
    held_cyc = exp_cyc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); start = (i == 3);
    end
    start = 1'b0;
    #2;
    check("halted_hold_state", 32'(run_state), 32'd2);
    check("halted_hold_cycle_cnt", cycle_cnt, held_cyc);

    // Reset out of HALTED, then an INS exception leads to FAULT.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b1;
    #2;
    check("rst_from_halt_state", 32'(run_state), 32'd0);
    check("rst_from_halt_cycle_cnt", cycle_cnt, 32'd0);
    @(negedge clk); start = 1'b0; W_stat = 3'b010;
    #2;
    check("fault_cycle_state", 32'(run_state), 32'd1);
    check("fault_cycle_ctl", 32'(ctl), 32'b0000_1100);
    @(negedge clk); drive_nops();
    #2;
    check("fault_state", 32'(run_state), 32'd3);
    check("fault_ctl", 32'(ctl), 32'(CTL_FREEZE));
    check("fault_cycle_cnt", cycle_cnt, 32'd1);

    // rst and start together: rst wins.
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    #2 check("rst_start_state", 32'(run_state), 32'd0);
    @(negedge clk);
    #2 check("rst_start_stays_idle", 32'(run_state), 32'd0);

    // Saturation: 20 RUN cycles, the 4-bit counter pins at 15.
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("sat_cycle_cnt32", cycle_cnt, 32'd20);
    check("sat_cycle_cnt4", 32'(cycle_cnt4), 32'd15);
    check("sat_state4", 32'(run_state4), 32'd1);

    // Mid-run reset clears state and counters at the next edge.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #2;
    check("midrst_state", 32'(run_state), 32'd0);
    check("midrst_ctl", 32'(ctl), 32'(CTL_IDLE));
    check("midrst_cycle_cnt", cycle_cnt, 32'd0);
    check("midrst_cycle_cnt4", 32'(cycle_cnt4), 32'd0);
    check("midrst_bubble_cnt", bubble_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
